// File: rtl/axis_pixel_proc_pkg.sv
// Shared definitions for the AXI-Stream pixel processor: register map, bit
// indices, pixel operation codes and the frame FSM state type.
package axis_pixel_proc_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_IER    = 8'h08;
  localparam logic [7:0] REG_ISR    = 8'h0C;
  localparam logic [7:0] REG_WIDTH  = 8'h10;
  localparam logic [7:0] REG_HEIGHT = 8'h14;
  localparam logic [7:0] REG_THRESH = 8'h18;

  localparam int CTRL_START   = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_MODE_LO = 2;

  localparam int IRQ_DONE     = 0;
  localparam int IRQ_LINE_ERR = 1;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_INVERT = 2'b01,
    MODE_THRESH = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Merge an AXI-Lite write into the current register image byte by byte.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) r[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered output buffer: one cycle of latency, full throughput,
// and ready toward the producer depends only on occupancy.
module axis_skid_buffer #(
  parameter int DATA_W = 34
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: the storage is reset too, so the data bus reads zero out of reset
  // instead of whatever the flops power up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/axis_pixel_proc_core.sv
// AXI-Stream pixel processor (pass / invert / threshold) with AXI-Lite control.
// Optional macro AXIS_PIXEL_SOF_SYNC_EN: drop input beats until the first TUSER beat.
module axis_pixel_proc_core
  import axis_pixel_proc_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int PPC     = 4,
  parameter int DIM_W   = 12,
  parameter int ADDR_W  = 5
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [ADDR_W-1:0]      s_axi_CONTROL_BUS_AWADDR,
  input  logic                   s_axi_CONTROL_BUS_AWVALID,
  output logic                   s_axi_CONTROL_BUS_AWREADY,
  input  logic [31:0]            s_axi_CONTROL_BUS_WDATA,
  input  logic [3:0]             s_axi_CONTROL_BUS_WSTRB,
  input  logic                   s_axi_CONTROL_BUS_WVALID,
  output logic                   s_axi_CONTROL_BUS_WREADY,
  output logic [1:0]             s_axi_CONTROL_BUS_BRESP,
  output logic                   s_axi_CONTROL_BUS_BVALID,
  input  logic                   s_axi_CONTROL_BUS_BREADY,
  input  logic [ADDR_W-1:0]      s_axi_CONTROL_BUS_ARADDR,
  input  logic                   s_axi_CONTROL_BUS_ARVALID,
  output logic                   s_axi_CONTROL_BUS_ARREADY,
  output logic [31:0]            s_axi_CONTROL_BUS_RDATA,
  output logic [1:0]             s_axi_CONTROL_BUS_RRESP,
  output logic                   s_axi_CONTROL_BUS_RVALID,
  input  logic                   s_axi_CONTROL_BUS_RREADY,
  output logic                   interrupt,
  input  logic                   INPUT_STREAM_TVALID,
  output logic                   INPUT_STREAM_TREADY,
  input  logic [PIXEL_W*PPC-1:0] INPUT_STREAM_TDATA,
  input  logic                   INPUT_STREAM_TUSER,
  input  logic                   INPUT_STREAM_TLAST,
  output logic                   OUTPUT_STREAM_TVALID,
  input  logic                   OUTPUT_STREAM_TREADY,
  output logic [PIXEL_W*PPC-1:0] OUTPUT_STREAM_TDATA,
  output logic [PIXEL_W*PPC/8-1:0] OUTPUT_STREAM_TKEEP,
  output logic [PIXEL_W*PPC/8-1:0] OUTPUT_STREAM_TSTRB,
  output logic                   OUTPUT_STREAM_TUSER,
  output logic                   OUTPUT_STREAM_TLAST
);

  localparam int DATA_W = PIXEL_W * PPC;

  logic               auto_restart;
  mode_e              mode;
  logic [1:0]         ier, isr, isr_set, isr_clr;
  logic [DIM_W-1:0]   width, height;
  logic [PIXEL_W-1:0] thresh;

  state_e             state;
  logic [DIM_W-1:0]   col, row;
  mode_e              frame_mode;
  logic [PIXEL_W-1:0] frame_thresh;

  logic               wr_en, rd_en, start_pulse, dims_zero;
  logic [31:0]        wr_val;
  logic               in_hs, beat_take, at_eol, at_last_row, sof_wait, drop;
  logic               buf_in_ready, buf_out_valid;
  logic [DATA_W-1:0]  proc_data;
  logic [PIXEL_W-1:0] pix;
  logic               unused_ok;

  function automatic logic [31:0] reg_read(input logic [ADDR_W-1:0] addr);
    logic [31:0] v;
    v = '0;
    case (addr)
      ADDR_W'(REG_CTRL):   v = {28'd0, mode, auto_restart, 1'b0};
      ADDR_W'(REG_STATUS): v = {29'd0, sof_wait, state != ST_IDLE, state == ST_IDLE};
      ADDR_W'(REG_IER):    v = {30'd0, ier};
      ADDR_W'(REG_ISR):    v = {30'd0, isr};
      ADDR_W'(REG_WIDTH):  v = 32'(width);
      ADDR_W'(REG_HEIGHT): v = 32'(height);
      ADDR_W'(REG_THRESH): v = 32'(thresh);
      default:             v = '0;
    endcase
    return v;
  endfunction

  assign wr_en  = s_axi_CONTROL_BUS_AWREADY && s_axi_CONTROL_BUS_AWVALID && s_axi_CONTROL_BUS_WVALID;
  assign rd_en  = s_axi_CONTROL_BUS_ARREADY && s_axi_CONTROL_BUS_ARVALID;
  assign wr_val = apply_wstrb(reg_read(s_axi_CONTROL_BUS_AWADDR), s_axi_CONTROL_BUS_WDATA,
                              s_axi_CONTROL_BUS_WSTRB);
  assign start_pulse = wr_en && (s_axi_CONTROL_BUS_AWADDR == ADDR_W'(REG_CTRL)) && wr_val[CTRL_START];
  assign isr_clr = (wr_en && (s_axi_CONTROL_BUS_AWADDR == ADDR_W'(REG_ISR)) && s_axi_CONTROL_BUS_WSTRB[0])
                   ? s_axi_CONTROL_BUS_WDATA[1:0] : 2'b00;
  assign dims_zero = (width == '0) || (height == '0);

  assign s_axi_CONTROL_BUS_BRESP = 2'b00;
  assign s_axi_CONTROL_BUS_RRESP = 2'b00;
  assign unused_ok = ^{wr_val, INPUT_STREAM_TUSER};

  // NOTE: every sequential block uses non-blocking assignments so all flops
  // see the same pre-edge values regardless of evaluation order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_CONTROL_BUS_AWREADY <= 1'b0;
      s_axi_CONTROL_BUS_WREADY  <= 1'b0;
      s_axi_CONTROL_BUS_BVALID  <= 1'b0;
      s_axi_CONTROL_BUS_ARREADY <= 1'b0;
      s_axi_CONTROL_BUS_RVALID  <= 1'b0;
      s_axi_CONTROL_BUS_RDATA   <= '0;
      auto_restart <= 1'b0;
      mode         <= MODE_PASS;
      ier          <= '0;
      isr          <= '0;
      width        <= '0;
      height       <= '0;
      thresh       <= '0;
      interrupt    <= 1'b0;
    end else begin
      // Ready pulses for exactly one cycle; the handshake lands on the next edge.
      s_axi_CONTROL_BUS_AWREADY <= !s_axi_CONTROL_BUS_AWREADY && s_axi_CONTROL_BUS_AWVALID &&
                                   s_axi_CONTROL_BUS_WVALID && !s_axi_CONTROL_BUS_BVALID;
      s_axi_CONTROL_BUS_WREADY  <= !s_axi_CONTROL_BUS_AWREADY && s_axi_CONTROL_BUS_AWVALID &&
                                   s_axi_CONTROL_BUS_WVALID && !s_axi_CONTROL_BUS_BVALID;
      s_axi_CONTROL_BUS_ARREADY <= !s_axi_CONTROL_BUS_ARREADY && s_axi_CONTROL_BUS_ARVALID &&
                                   !s_axi_CONTROL_BUS_RVALID;
      if (s_axi_CONTROL_BUS_BVALID && s_axi_CONTROL_BUS_BREADY) s_axi_CONTROL_BUS_BVALID <= 1'b0;
      if (wr_en) begin
        s_axi_CONTROL_BUS_BVALID <= 1'b1;
        case (s_axi_CONTROL_BUS_AWADDR)
          ADDR_W'(REG_CTRL): begin
            auto_restart <= wr_val[CTRL_AUTO];
            mode         <= mode_e'(wr_val[CTRL_MODE_LO +: 2]);
          end
          ADDR_W'(REG_IER):    ier    <= wr_val[1:0];
          ADDR_W'(REG_WIDTH):  width  <= wr_val[DIM_W-1:0];
          ADDR_W'(REG_HEIGHT): height <= wr_val[DIM_W-1:0];
          ADDR_W'(REG_THRESH): thresh <= wr_val[PIXEL_W-1:0];
          default: ;
        endcase
      end
      if (rd_en) begin
        s_axi_CONTROL_BUS_RVALID <= 1'b1;
        s_axi_CONTROL_BUS_RDATA  <= reg_read(s_axi_CONTROL_BUS_ARADDR);
      end else if (s_axi_CONTROL_BUS_RVALID && s_axi_CONTROL_BUS_RREADY) begin
        s_axi_CONTROL_BUS_RVALID <= 1'b0;
      end
      // Hardware set wins over a simultaneous software clear.
      isr       <= (isr & ~isr_clr) | isr_set;
      interrupt <= |(isr & ier);
    end
  end

  assign INPUT_STREAM_TREADY = (state == ST_RUN) && buf_in_ready;
  assign in_hs       = INPUT_STREAM_TVALID && INPUT_STREAM_TREADY;
  assign beat_take   = in_hs && !drop;
  assign at_eol      = (col == width - 1'b1);
  assign at_last_row = (row == height - 1'b1);

`ifdef AXIS_PIXEL_SOF_SYNC_EN
  assign sof_wait = (state == ST_RUN) && (col == '0) && (row == '0);
  assign drop     = sof_wait && !INPUT_STREAM_TUSER;
`else
  assign sof_wait = 1'b0;
  assign drop     = 1'b0;
`endif

  assign isr_set[IRQ_DONE]     = (state == ST_DONE);
  assign isr_set[IRQ_LINE_ERR] = (beat_take && (INPUT_STREAM_TLAST != at_eol)) ||
                                 ((state == ST_IDLE) && start_pulse && dims_zero);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_IDLE;
      col          <= '0;
      row          <= '0;
      frame_mode   <= MODE_PASS;
      frame_thresh <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start_pulse) begin
          col          <= '0;
          row          <= '0;
          frame_mode   <= mode_e'(wr_val[CTRL_MODE_LO +: 2]);
          frame_thresh <= thresh;
          state        <= dims_zero ? ST_DONE : ST_RUN;
        end
        ST_RUN: if (beat_take) begin
          if (at_eol) begin
            col <= '0;
            if (at_last_row) begin
              row   <= '0;
              state <= ST_DRAIN;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        ST_DRAIN: if (!buf_out_valid) state <= ST_DONE;
        default: begin
          if (auto_restart && !dims_zero) begin
            col          <= '0;
            row          <= '0;
            frame_mode   <= mode;
            frame_thresh <= thresh;
            state        <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // NOTE: outputs get a default before the loop so no path leaves them unassigned.
  always_comb begin
    proc_data = '0;
    pix       = '0;
    for (int i = 0; i < PPC; i++) begin
      pix = INPUT_STREAM_TDATA[i*PIXEL_W +: PIXEL_W];
      case (frame_mode)
        MODE_INVERT: proc_data[i*PIXEL_W +: PIXEL_W] = ~pix;
        MODE_THRESH: proc_data[i*PIXEL_W +: PIXEL_W] = (pix >= frame_thresh) ? {PIXEL_W{1'b1}} : '0;
        default:     proc_data[i*PIXEL_W +: PIXEL_W] = pix;
      endcase
    end
  end

  axis_skid_buffer #(.DATA_W(DATA_W + 2)) u_out_buf (
    .clk       (aclk),
    .rst_n     (aresetn),
    .in_valid  (beat_take),
    .in_ready  (buf_in_ready),
    .in_data   ({(col == '0) && (row == '0), at_eol, proc_data}),
    .out_valid (buf_out_valid),
    .out_ready (OUTPUT_STREAM_TREADY),
    .out_data  ({OUTPUT_STREAM_TUSER, OUTPUT_STREAM_TLAST, OUTPUT_STREAM_TDATA})
  );

  assign OUTPUT_STREAM_TVALID = buf_out_valid;
  assign OUTPUT_STREAM_TKEEP  = '1;
  assign OUTPUT_STREAM_TSTRB  = '1;

endmodule
